// File: rtl/array_multiplier_4x4.sv
// Unsigned 4x4 carry-save array multiplier with a registered 8-bit product.
// One-cycle latency, one operand pair accepted per clock, no back-pressure.

// Full-adder cell used throughout the array and the final ripple row.
module array_multiplier_4x4_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain full-adder equations.
    always_comb begin
        sum  = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end

endmodule

module array_multiplier_4x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p,
    output logic       out_valid
);

    // pp[i][j] = a[j] & b[i]
    logic [3:0][3:0] pp;

    // Running sum/carry vectors per array row.
    // Row k cell j has weight k+j; its carry has weight k+j+1.
    logic [3:0][3:0] rs;
    logic [3:0][3:0] rc;

    // Final ripple row: sums and inter-cell carries.
    logic [2:0] fr_sum;
    logic [2:0] fr_carry;

    logic [7:0] prod;

    logic [7:0] p_q;
    logic [7:0] p_d;
    logic       out_valid_q;
    logic       out_valid_d;

    // Partial-product AND plane.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp[i][j] = a[j] & b[i];
            end
        end
    end

    // Row 0 is just the first partial-product row with no carries.
    assign rs[0] = pp[0];
    assign rc[0] = 4'b0000;

    // Carry-save rows 1..3: add the next partial-product row to the
    // previous row's sum (shifted down one) and its carries.
    for (genvar k = 1; k < 4; k++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_cell
            logic y_in;
            if (j < 3) begin : g_mid
                assign y_in = rs[k-1][j+1];
            end else begin : g_top
                assign y_in = 1'b0;
            end
            array_multiplier_4x4_fa u_fa (
                .x    (pp[k][j]),
                .y    (y_in),
                .cin  (rc[k-1][j]),
                .sum  (rs[k][j]),
                .cout (rc[k][j])
            );
        end
    end

    // Ripple row resolves the leftover sum/carry vectors into p[6:4].
    array_multiplier_4x4_fa u_fr0 (
        .x    (rs[3][1]),
        .y    (rc[3][0]),
        .cin  (1'b0),
        .sum  (fr_sum[0]),
        .cout (fr_carry[0])
    );

    array_multiplier_4x4_fa u_fr1 (
        .x    (rs[3][2]),
        .y    (rc[3][1]),
        .cin  (fr_carry[0]),
        .sum  (fr_sum[1]),
        .cout (fr_carry[1])
    );

    array_multiplier_4x4_fa u_fr2 (
        .x    (rs[3][3]),
        .y    (rc[3][2]),
        .cin  (fr_carry[1]),
        .sum  (fr_sum[2]),
        .cout (fr_carry[2])
    );

    // Top bit: the last carry and the top array carry can never both be
    // set (15*15 fits in 8 bits), so an XOR closes the sum.
    always_comb begin
        prod[0]   = rs[0][0];
        prod[1]   = rs[1][0];
        prod[2]   = rs[2][0];
        prod[3]   = rs[3][0];
        prod[6:4] = fr_sum;
        prod[7]   = rc[3][3] ^ fr_carry[2];
    end

    // Next-state for the output register: capture on in_valid, else hold.
    always_comb begin
        p_d         = p_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            p_d         = prod;
            out_valid_d = 1'b1;
        end
    end

    // Output register with synchronous reset that overrides in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_multiplier_4x4.sv
// Scoreboard bench for array_multiplier_4x4: a cycle model pushes expected
// outputs at each edge, a monitor pops and compares on the falling edge.
module tb_array_multiplier_4x4;

    typedef struct {
        logic       v;
        logic [7:0] p;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       out_valid;

    exp_t exp_q[$];
    logic [7:0] m_p;
    int vectors;
    int miscompares;

    array_multiplier_4x4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .p         (p),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the output register must hold after each edge.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_p = 8'h00;
            e.v = 1'b0;
        end else if (in_valid) begin
            m_p = 8'(int'(a) * int'(b));
            e.v = 1'b1;
        end else begin
            e.v = 1'b0;
        end
        e.p = m_p;
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            vectors++;
            if (out_valid !== e.v) begin
                miscompares++;
                $display("FAIL out_valid t=%0t got=%b exp=%b",
                         $time, out_valid, e.v);
            end
            vectors++;
            if (p !== e.p) begin
                miscompares++;
                $display("FAIL product t=%0t a=%0d b=%0d got=%0d exp=%0d",
                         $time, a, b, p, e.p);
            end
        end
    end

    task automatic drive(input logic r, input logic v,
                         input logic [3:0] x, input logic [3:0] y);
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_p         = 8'h00;
        rst         = 1'b1;
        in_valid    = 1'b1;
        a           = 4'd15;
        b           = 4'd15;

        // Reset held two cycles with valid max operands.
        drive(1'b1, 1'b1, 4'd15, 4'd15);
        // Released, nothing valid: p stays 0.
        drive(1'b0, 1'b0, 4'd15, 4'd15);
        drive(1'b0, 1'b0, 4'd3, 4'd3);

        // Directed products.
        drive(1'b0, 1'b1, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 4'd3, 4'd4);
        drive(1'b0, 1'b1, 4'd9, 4'd15);
        drive(1'b0, 1'b1, 4'd15, 4'd15);
        drive(1'b0, 1'b1, 4'd7, 4'd10);

        // Hold: invalid operands must not disturb p.
        drive(1'b0, 1'b0, 4'd2, 4'd2);
        drive(1'b0, 1'b0, 4'd2, 4'd2);

        // Reset mid-stream wins over a valid pair.
        drive(1'b0, 1'b1, 4'd6, 4'd7);
        drive(1'b1, 1'b1, 4'd9, 4'd15);
        drive(1'b0, 1'b1, 4'd5, 4'd5);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 4'(i >> 4), 4'(i));
        end

        // Identity and zero, both operand orders.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'd1, 4'(i));
            drive(1'b0, 1'b1, 4'(i), 4'd1);
            drive(1'b0, 1'b1, 4'd0, 4'(i));
            drive(1'b0, 1'b1, 4'(i), 4'd0);
        end

        // Random mix of valid, idle and occasional reset cycles.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom), 4'($urandom));
        end

        drive(1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
